tt_um_calonso88_rsa_top: RTL and testbench

TT_UM_CALONSO88_RSA_TOP -- requirements
Module: tt_um_calonso88_rsa_top

---
 rtl/rsa_pkg.sv | 40 ++++
 rtl/rsa_if.sv | 13 +
 rtl/rsa_modmul.sv | 63 ++++++
 rtl/tt_um_calonso88_rsa_top.sv | 125 ++++++++++++
 tb/tb_tt_um_calonso88_rsa_top.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the 8-bit modular exponentiation tile:
// FSM states, register addresses, operand width and the multiplier step.
package rsa_pkg;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 81;

    localparam logic [2:0] ADDR_M = 3'd0;
    localparam logic [2:0] ADDR_E = 3'd1;
    localparam logic [2:0] ADDR_N = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_MUL,
        S_UPD,
        S_FIN
    } state_e;

    // One interleaved step: P = 2P mod N, then P = (P + Y) mod N when the bit is set.
    // Both partial sums stay below 2N, so a 9-bit accumulator never overflows.
    function automatic logic [WIDTH-1:0] modmul_step(
        input logic [WIDTH-1:0] p,
        input logic             bit_set,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH:0] n9;
        logic [WIDTH:0] acc;
        n9  = {1'b0, n};
        acc = {p, 1'b0};
        if (acc >= n9) acc = acc - n9;
        if (bit_set) begin
            acc = acc + {1'b0, y};
            if (acc >= n9) acc = acc - n9;
        end
        return acc[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rsa_if.sv
// Operand/result bundle between the exponentiation controller and a modular multiplier.
interface rsa_if;
    import rsa_pkg::*;

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] p;

    modport master (output start, x, y, n, input p);
    modport slave  (input start, x, y, n, output p);
endinterface

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: p = x*y mod n, x consumed MSB first,
// one bit per clock; the start edge performs the first of eight steps.
module rsa_modmul
    import rsa_pkg::*;
(
    input logic  clk,
    input logic  rst_n,
    rsa_if.slave mm
);

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             stepping;

    always_comb begin
        p_d      = p_q;
        x_d      = x_q;
        y_d      = y_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        stepping = mm.start | active_q;
        if (mm.start) begin
            p_d      = modmul_step('0, mm.x[WIDTH-1], mm.y, mm.n);
            x_d      = {mm.x[WIDTH-2:0], 1'b0};
            y_d      = mm.y;
            n_d      = mm.n;
            cnt_d    = 3'd1;
            active_d = 1'b1;
        end else if (active_q) begin
            p_d      = modmul_step(p_q, x_q[WIDTH-1], y_q, n_q);
            x_d      = {x_q[WIDTH-2:0], 1'b0};
            cnt_d    = cnt_q + 3'd1;
            active_d = (cnt_q != 3'd7);
        end
    end

    // The final step's value is forwarded so the controller can capture it on that same edge.
    assign mm.p = stepping ? p_d : p_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            p_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            p_q      <= p_d;
            x_q      <= x_d;
            y_q      <= y_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/tt_um_calonso88_rsa_top.sv
// 8-bit C = M^E mod N tile: register file, start-edge launch and right-to-left
// square-and-multiply controller driving two modular multipliers.
module tt_um_calonso88_rsa_top
    import rsa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e           state_q;
    logic [2:0]       cnt_q;
    logic [2:0]       k_q;
    logic [WIDTH-1:0] m_q, e_q, n_q;
    logic [WIDTH-1:0] wm_q, we_q, wn_q;
    logic [WIDTH-1:0] r_q, b_q, c_q;
    logic             busy_q, done_q, start_q;

    logic [2:0]       addr;
    logic             wr_ok, start_in, launch;
    logic [WIDTH-1:0] m_nxt, e_nxt, n_nxt;
    logic             unused_inputs;

    assign addr          = uio_in[2:0];
    assign start_in      = uio_in[4];
    assign unused_inputs = &{1'b0, ena, uio_in[7:5]};

    // Writes land before a same-cycle launch, so the launch captures the *_nxt values.
    assign wr_ok  = uio_in[3] & ~busy_q;
    assign m_nxt  = (wr_ok && addr == ADDR_M) ? ui_in : m_q;
    assign e_nxt  = (wr_ok && addr == ADDR_E) ? ui_in : e_q;
    assign n_nxt  = (wr_ok && addr == ADDR_N) ? ui_in : n_q;
    assign launch = start_in & ~start_q & ~busy_q;

    // mm_rb computes R*B, mm_bb computes B*B (and M*1 during PRE to reduce M below N).
    rsa_if mm_rb ();
    rsa_if mm_bb ();

    assign mm_rb.start = (state_q == S_MUL) && (cnt_q == 3'd0);
    assign mm_rb.x     = r_q;
    assign mm_rb.y     = b_q;
    assign mm_rb.n     = wn_q;

    assign mm_bb.start = ((state_q == S_PRE) || (state_q == S_MUL)) && (cnt_q == 3'd0);
    assign mm_bb.x     = (state_q == S_PRE) ? wm_q : b_q;
    assign mm_bb.y     = (state_q == S_PRE) ? 8'd1 : b_q;
    assign mm_bb.n     = wn_q;

    rsa_modmul u_mul_rb (.clk(clk), .rst_n(rst_n), .mm(mm_rb));
    rsa_modmul u_mul_bb (.clk(clk), .rst_n(rst_n), .mm(mm_bb));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            wm_q    <= '0;
            we_q    <= '0;
            wn_q    <= '0;
            r_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= start_in;
            m_q     <= m_nxt;
            e_q     <= e_nxt;
            n_q     <= n_nxt;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        wm_q    <= m_nxt;
                        we_q    <= e_nxt;
                        wn_q    <= n_nxt;
                        r_q     <= 8'd1;
                        k_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        b_q     <= mm_bb.p;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_q <= S_UPD;
                end
                S_UPD: begin
                    if (we_q[k_q]) r_q <= mm_rb.p;
                    b_q     <= mm_bb.p;
                    k_q     <= k_q + 3'd1;
                    state_q <= (k_q == 3'd7) ? S_FIN : S_MUL;
                end
                S_FIN: begin
                    c_q     <= (wn_q < 8'd2) ? 8'd0 : r_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uo_out  = c_q;
    assign uio_out = {1'b0, done_q, busy_q, 5'b00000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_calonso88_rsa_top.sv
// Directed bench for the modular exponentiation tile: a timing/result model built
// from plain arithmetic, a per-cycle compare process and literal spot checks.
module tb_tt_um_calonso88_rsa_top;
    import rsa_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [2:0] addr;
    logic       wr_en;
    logic       start_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign uio_in = {3'b000, start_in, wr_en, addr};

    always #5 clk = ~clk;

    tt_um_calonso88_rsa_top dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    rsa_if mm_tb ();
    rsa_modmul u_mm (.clk(clk), .rst_n(rst_n), .mm(mm_tb));

    int         checks = 0;
    int         failures = 0;
    logic       chk_en = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] modexp(input int m, input int e, input int n);
        int r;
        if (n < 2) return 8'd0;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * m) % n;
        return r[7:0];
    endfunction

    // Behavioural model: register file, start-edge launch, fixed 81-edge latency.
    logic [7:0] mdl_m, mdl_e, mdl_n, mdl_c, mdl_res;
    logic       mdl_busy, mdl_done, mdl_prev;
    int         mdl_cnt;

    always @(posedge clk) begin
        if (rst_n) begin
            mdl_m = 0; mdl_e = 0; mdl_n = 0; mdl_c = 0; mdl_res = 0;
            mdl_busy = 0; mdl_done = 0; mdl_prev = 0; mdl_cnt = 0;
        end else begin
            if (wr_en && !mdl_busy) begin
                case (addr)
                    3'd0: mdl_m = ui_in;
                    3'd1: mdl_e = ui_in;
                    3'd2: mdl_n = ui_in;
                    default: ;
                endcase
            end
            if (mdl_busy) begin
                mdl_cnt++;
                if (mdl_cnt == LATENCY) begin
                    mdl_busy = 0;
                    mdl_done = 1;
                    mdl_c = mdl_res;
                    exp_q.push_back(mdl_res);
                end
            end else if (start_in && !mdl_prev) begin
                mdl_res  = modexp(mdl_m, mdl_e, mdl_n);
                mdl_busy = 1;
                mdl_done = 0;
                mdl_cnt  = 0;
            end
            mdl_prev = start_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check8("cyc_uo_out", uo_out, mdl_c);
            check8("cyc_uio_out", uio_out, {1'b0, mdl_done, mdl_busy, 5'b00000});
            check8("cyc_uio_oe", uio_oe, 8'hE0);
        end
    end

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; ui_in = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_ops(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n);
        do_write(ADDR_M, m);
        do_write(ADDR_E, e);
        do_write(ADDR_N, n);
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!uio_out[6] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check8({tag, "_done"}, {7'd0, uio_out[6]}, 8'd1);
    endtask

    task automatic sb_pop(input string tag);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_sb actual=empty required=entry", tag);
        end else begin
            check8({tag, "_sb"}, uo_out, exp_q.pop_front());
        end
    endtask

    // Launch with current registers and count edges until done; hold keeps start high.
    task automatic launch_and_check(input logic [7:0] expv, input logic hold, input string tag);
        int cyc;
        @(negedge clk);
        start_in = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) start_in = 1'b0;
        end while (!uio_out[6] && cyc < 200);
        check8({tag, "_latency"}, 8'(cyc - 1), 8'd81);
        check8({tag, "_result"}, uo_out, expv);
        check8({tag, "_busy_at_done"}, {7'd0, uio_out[5]}, 8'd0);
        sb_pop(tag);
    endtask

    typedef struct {
        logic [7:0] m;
        logic [7:0] e;
        logic [7:0] n;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'd88,  8'd7,   8'd187, 8'd11};
        vecs[1] = '{8'd11,  8'd23,  8'd187, 8'd88};
        vecs[2] = '{8'd200, 8'd1,   8'd187, 8'd13};
        vecs[3] = '{8'd5,   8'd0,   8'd33,  8'd1};
        vecs[4] = '{8'd9,   8'd3,   8'd1,   8'd0};
        vecs[5] = '{8'd0,   8'd5,   8'd187, 8'd0};
        vecs[6] = '{8'd3,   8'd4,   8'd0,   8'd0};
        vecs[7] = '{8'd255, 8'd255, 8'd251, 8'd20};

        rst_n = 1'b1; ena = 1'b1; ui_in = 0; addr = 0; wr_en = 0; start_in = 0;
        mm_tb.start = 1'b0; mm_tb.x = 0; mm_tb.y = 0; mm_tb.n = 0;
        repeat (3) @(negedge clk);
        check8("reset_uo_out", uo_out, 8'd0);
        check8("reset_uio_out", uio_out, 8'd0);
        check8("reset_uio_oe", uio_oe, 8'hE0);
        chk_en = 1'b1;
        rst_n = 1'b0;

        check8("model_pin_88_7_187", modexp(88, 7, 187), 8'd11);
        check8("model_pin_11_23_187", modexp(11, 23, 187), 8'd88);
        check8("model_pin_255_255_251", modexp(255, 255, 251), 8'd20);

        foreach (vecs[i]) begin
            write_ops(vecs[i].m, vecs[i].e, vecs[i].n);
            launch_and_check(vecs[i].r, 1'b0, $sformatf("vec%0d", i));
        end

        // Writes to unmapped addresses must leave M/E/N alone.
        write_ops(8'd88, 8'd7, 8'd187);
        for (int a = 3; a < 8; a++) do_write(3'(a), 8'd99);
        launch_and_check(8'd11, 1'b0, "unmapped_addr");

        // Start held high across completion: exactly one launch.
        write_ops(8'd7, 8'd3, 8'd33);
        launch_and_check(8'd13, 1'b1, "held_start");
        repeat (100) @(negedge clk);
        check8("held_start_no_relaunch", {7'd0, uio_out[5]}, 8'd0);
        start_in = 1'b0;

        // Write and new start edge while busy are ignored.
        @(negedge clk); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        repeat (20) @(negedge clk);
        do_write(ADDR_N, 8'd187);
        @(negedge clk); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        wait_done("busy_ignore");
        check8("busy_ignore_result", uo_out, 8'd13);
        sb_pop("busy_ignore");
        launch_and_check(8'd13, 1'b0, "n_unchanged");

        // Reset mid-operation aborts with nothing written to C.
        write_ops(8'd88, 8'd7, 8'd187);
        @(negedge clk); start_in = 1'b1;
        @(negedge clk); start_in = 1'b0;
        repeat (38) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check8("abort_busy", {7'd0, uio_out[5]}, 8'd0);
        check8("abort_done", {7'd0, uio_out[6]}, 8'd0);
        check8("abort_uo_out", uo_out, 8'd0);
        rst_n = 1'b0;
        launch_and_check(8'd0, 1'b0, "post_reset_zero_regs");
        write_ops(8'd88, 8'd7, 8'd187);
        launch_and_check(8'd11, 1'b0, "post_reset_fresh");

        // Stand-alone multiplier through the interface.
        @(negedge clk);
        mm_tb.start = 1'b1; mm_tb.x = 8'd88; mm_tb.y = 8'd88; mm_tb.n = 8'd187;
        @(negedge clk);
        mm_tb.start = 1'b0;
        repeat (7) @(negedge clk);
        check8("modmul_88x88_187", mm_tb.p, 8'd77);
        @(negedge clk);
        mm_tb.start = 1'b1; mm_tb.x = 8'd200; mm_tb.y = 8'd100; mm_tb.n = 8'd251;
        @(negedge clk);
        mm_tb.start = 1'b0;
        repeat (7) @(negedge clk);
        check8("modmul_200x100_251", mm_tb.p, 8'd171);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
